mandel_dispatch: RTL and testbench

MANDEL_DISPATCH -- requirements
Module: mandel_dispatch

---
 rtl/mandel_dispatch.sv | 159 +++++++++++++++
 tb/tb_mandel_dispatch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_dispatch.sv
// Mandelbrot frame dispatcher: walks the raster pixel by pixel, launches the solver on each
// point and streams the captured iteration count out as an addressed result write.
module mandel_dispatch #(
    parameter int unsigned H_PIX = 640,
    parameter int unsigned V_PIX = 480,
    localparam int unsigned CW = 27,
    localparam int unsigned IW = 13,
    localparam int unsigned AW = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] x_start,
    input  logic [CW-1:0] y_start,
    input  logic [CW-1:0] dx,
    input  logic [CW-1:0] dy,
    input  logic [IW-1:0] max_iter,
    output logic          slv_reset,
    output logic [CW-1:0] slv_cr,
    output logic [CW-1:0] slv_ci,
    output logic [IW-1:0] slv_max_iter,
    input  logic [IW-1:0] slv_iter,
    input  logic          slv_done,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [IW-1:0] wr_iter,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int unsigned YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, WRITE, ADVANCE} state_t;

    state_t        state, state_n;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic          first_wait, first_wait_n;
    logic [CW-1:0] x0, x0_n, dx_q, dx_q_n, dy_q, dy_q_n;
    logic [CW-1:0] slv_cr_n, slv_ci_n;
    logic [IW-1:0] slv_max_iter_n, wr_iter_n;
    logic [AW-1:0] wr_addr_n;
    logic          slv_reset_n, wr_valid_n, busy_n, frame_done_n;

    // Next-state and datapath updates; status outputs are registered from the next state.
    always_comb begin
        state_n        = state;
        x_n            = x;
        y_n            = y;
        first_wait_n   = first_wait;
        x0_n           = x0;
        dx_q_n         = dx_q;
        dy_q_n         = dy_q;
        slv_cr_n       = slv_cr;
        slv_ci_n       = slv_ci;
        slv_max_iter_n = slv_max_iter;
        wr_iter_n      = wr_iter;
        wr_addr_n      = wr_addr;
        frame_done_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n        = LAUNCH;
                    x0_n           = x_start;
                    dx_q_n         = dx;
                    dy_q_n         = dy;
                    slv_max_iter_n = max_iter;
                    slv_cr_n       = x_start;
                    slv_ci_n       = y_start;
                    x_n            = '0;
                    y_n            = '0;
                    wr_addr_n      = '0;
                end
            end
            LAUNCH: begin
                state_n      = WAIT;
                first_wait_n = 1'b1;
            end
            WAIT: begin
                // slv_done may still reflect the previous pixel on the first cycle
                first_wait_n = 1'b0;
                if (!first_wait && slv_done) begin
                    wr_iter_n = slv_iter;
                    state_n   = WRITE;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    state_n = ADVANCE;
                end
            end
            ADVANCE: begin
                if (x != XW'(H_PIX - 1)) begin
                    x_n       = x + XW'(1);
                    slv_cr_n  = slv_cr + dx_q;
                    wr_addr_n = wr_addr + AW'(1);
                    state_n   = LAUNCH;
                end else if (y != YW'(V_PIX - 1)) begin
                    x_n       = '0;
                    y_n       = y + YW'(1);
                    slv_cr_n  = x0;
                    slv_ci_n  = slv_ci + dy_q;
                    wr_addr_n = wr_addr + AW'(1);
                    state_n   = LAUNCH;
                end else begin
                    frame_done_n = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        slv_reset_n = (state_n == IDLE) || (state_n == LAUNCH);
        wr_valid_n  = (state_n == WRITE);
        busy_n      = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            first_wait   <= 1'b0;
            x0           <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            slv_cr       <= '0;
            slv_ci       <= '0;
            slv_max_iter <= '0;
            wr_iter      <= '0;
            wr_addr      <= '0;
            slv_reset    <= 1'b1;
            wr_valid     <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            x            <= x_n;
            y            <= y_n;
            first_wait   <= first_wait_n;
            x0           <= x0_n;
            dx_q         <= dx_q_n;
            dy_q         <= dy_q_n;
            slv_cr       <= slv_cr_n;
            slv_ci       <= slv_ci_n;
            slv_max_iter <= slv_max_iter_n;
            wr_iter      <= wr_iter_n;
            wr_addr      <= wr_addr_n;
            slv_reset    <= slv_reset_n;
            wr_valid     <= wr_valid_n;
            busy         <= busy_n;
            frame_done   <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_mandel_dispatch.sv
// Bench for mandel_dispatch on a 4x2 raster with a behavioural solver answering
// three cycles after its reset falls; a raster model predicts every write.
module tb_mandel_dispatch;

    localparam int H = 4;
    localparam int V = 2;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        reset, start, wr_ready;
    logic [26:0] x_start, y_start, dx, dy;
    logic [12:0] max_iter;
    logic        slv_reset, slv_done, wr_valid, busy, frame_done;
    logic [26:0] slv_cr, slv_ci;
    logic [12:0] slv_max_iter, slv_iter, wr_iter;
    logic [18:0] wr_addr;

    always #5 clk = ~clk;

    mandel_dispatch #(.H_PIX(H), .V_PIX(V)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x_start(x_start), .y_start(y_start), .dx(dx), .dy(dy), .max_iter(max_iter),
        .slv_reset(slv_reset), .slv_cr(slv_cr), .slv_ci(slv_ci), .slv_max_iter(slv_max_iter),
        .slv_iter(slv_iter), .slv_done(slv_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_iter(wr_iter),
        .busy(busy), .frame_done(frame_done)
    );

    // Behavioural solver; the override lets a test inject stale or chosen results.
    logic [1:0]  sol_cnt;
    logic        ovr_en, ovr_done;
    logic [12:0] ovr_iter;

    function automatic logic [12:0] iter_of(logic [26:0] cr, logic [26:0] ci);
        return {1'b0, cr[26:21], ci[26:21]};
    endfunction

    always_ff @(posedge clk) begin
        if (slv_reset) sol_cnt <= 2'd0;
        else if (sol_cnt != 2'd3) sol_cnt <= sol_cnt + 2'd1;
    end
    assign slv_done = ovr_en ? ovr_done : (sol_cnt == 2'd3);
    assign slv_iter = ovr_en ? ovr_iter : iter_of(slv_cr, slv_ci);

    // Raster model: pixel i sits at x=i%H, y=i/H with point start + x*dx, start + y*dy.
    logic [26:0] exp_x0, exp_y0, exp_dx, exp_dy;
    logic [12:0] exp_max;

    function automatic logic [26:0] m_cr(int i);
        logic [26:0] xi;
        xi = 27'(i % H);
        return exp_x0 + xi * exp_dx;
    endfunction

    function automatic logic [26:0] m_ci(int i);
        logic [26:0] yi;
        yi = 27'(i / H);
        return exp_y0 + yi * exp_dy;
    endfunction

    int errors = 0;
    int checks = 0;
    int idx = 0, fd_cnt = 0, n_last = 0, cyc = 0;
    logic        skip_iter;
    logic        pend = 1'b0;
    logic [18:0] h_addr;
    logic [12:0] h_iter;
    logic [26:0] h_cr, h_ci;
    logic [26:0] cap_cr[N], cap_ci[N];
    logic [18:0] cap_addr[N];
    int          acc_cyc[N];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Per-cycle comparison of the DUT against the raster model.
    task automatic compare_cycle();
        cyc++;
        if (reset) begin
            idx  = 0;
            pend = 1'b0;
            return;
        end
        if (busy) chk("slv_max_iter", 32'(slv_max_iter), 32'(exp_max));
        if (busy && slv_reset && idx < N) begin
            chk("launch_cr", 32'(slv_cr), 32'(m_cr(idx)));
            chk("launch_ci", 32'(slv_ci), 32'(m_ci(idx)));
        end
        if (pend) begin
            chk("hold_valid", 32'(wr_valid), 32'd1);
            chk("hold_addr", 32'(wr_addr), 32'(h_addr));
            chk("hold_iter", 32'(wr_iter), 32'(h_iter));
            chk("hold_cr", 32'(slv_cr), 32'(h_cr));
            chk("hold_ci", 32'(slv_ci), 32'(h_ci));
        end
        if (wr_valid) begin
            if (idx < N) begin
                chk("wr_addr", 32'(wr_addr), 32'(idx));
                chk("wr_cr", 32'(slv_cr), 32'(m_cr(idx)));
                chk("wr_ci", 32'(slv_ci), 32'(m_ci(idx)));
                if (!skip_iter) chk("wr_iter", 32'(wr_iter), 32'(iter_of(m_cr(idx), m_ci(idx))));
                if (wr_ready) begin
                    cap_cr[idx]   = slv_cr;
                    cap_ci[idx]   = slv_ci;
                    cap_addr[idx] = wr_addr;
                    acc_cyc[idx]  = cyc;
                    idx++;
                end
            end else begin
                chk("extra_write", 32'(idx), 32'(N - 1));
            end
        end
        pend   = wr_valid && !wr_ready;
        h_addr = wr_addr;
        h_iter = wr_iter;
        h_cr   = slv_cr;
        h_ci   = slv_ci;
        if (frame_done) begin
            chk("fd_busy", 32'(busy), 32'd0);
            chk("fd_writes", 32'(idx), 32'(N));
            fd_cnt++;
            n_last = idx;
            idx    = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(logic [26:0] x0, logic [26:0] y0, logic [26:0] ddx,
                               logic [26:0] ddy, logic [12:0] mx);
        exp_x0 = x0; exp_y0 = y0; exp_dx = ddx; exp_dy = ddy; exp_max = mx;
        x_start = x0; y_start = y0; dx = ddx; dy = ddy; max_iter = mx;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(string name);
        int fd0;
        int n;
        fd0 = fd_cnt;
        n = 0;
        while (fd_cnt == fd0 && n < 300) begin
            tick();
            n++;
        end
        if (fd_cnt == fd0) fail_timeout(name);
    endtask

    task automatic wait_launch(string name);
        int n;
        n = 0;
        while (!(busy && slv_reset) && n < 50) begin
            tick();
            n++;
        end
        if (!(busy && slv_reset)) fail_timeout(name);
    endtask

    task automatic wait_valid(string name);
        int n;
        n = 0;
        while (!wr_valid && n < 50) begin
            tick();
            n++;
        end
        if (!wr_valid) fail_timeout(name);
    endtask

    initial begin
        int fd_before;
        int n;
        reset = 1'b1; start = 1'b0; wr_ready = 1'b1;
        x_start = '0; y_start = '0; dx = '0; dy = '0; max_iter = '0;
        ovr_en = 1'b0; ovr_done = 1'b0; ovr_iter = '0; skip_iter = 1'b0;
        exp_x0 = '0; exp_y0 = '0; exp_dx = '0; exp_dy = '0; exp_max = '0;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Reset values
        tick(); tick();
        chk("rst_slv_reset", 32'(slv_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_iter", 32'(wr_iter), 32'd0);
        chk("rst_cr", 32'(slv_cr), 32'd0);
        chk("rst_ci", 32'(slv_ci), 32'd0);
        chk("rst_max_iter", 32'(slv_max_iter), 32'd0);
        reset = 1'b0;
        tick();

        // Frame A: nominal raster
        start_frame(27'h7000000, 27'h0800000, 27'h0400000, 27'h7C00000, 13'd100);
        wait_frame("A_frame_done");
        chk("A_writes", 32'(n_last), 32'(N));
        chk("A_fd_count", 32'(fd_cnt), 32'd1);
        chk("A_busy_after", 32'(busy), 32'd0);
        chk("A_fd_one_cycle", 32'(frame_done), 32'd0);
        chk("A_cr0", 32'(cap_cr[0]), 32'h7000000);
        chk("A_cr1", 32'(cap_cr[1]), 32'h7400000);
        chk("A_cr3", 32'(cap_cr[3]), 32'h7C00000);
        chk("A_cr4", 32'(cap_cr[4]), 32'h7000000);
        chk("A_ci3", 32'(cap_ci[3]), 32'h0800000);
        chk("A_ci4", 32'(cap_ci[4]), 32'h0400000);
        chk("A_addr7", 32'(cap_addr[7]), 32'd7);
        chk("A_pixel_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);
        chk("A_row_period", 32'(acc_cyc[4] - acc_cyc[3]), 32'd7);

        // Frame B: wrapping coordinates, backpressure and an ignored start
        wr_ready = 1'b0;
        start_frame(27'h3FFFFFF, 27'h4000000, 27'h0000001, 27'h4000000, 13'h1FFF);
        wait_valid("B_first_valid");
        h_addr = wr_addr; h_iter = wr_iter; h_cr = slv_cr;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("B_stall_valid", 32'(wr_valid), 32'd1);
            chk("B_stall_addr", 32'(wr_addr), 32'(h_addr));
            chk("B_stall_iter", 32'(wr_iter), 32'(h_iter));
            chk("B_stall_cr", 32'(slv_cr), 32'(h_cr));
        end
        chk("B_stall_iter_val", 32'(wr_iter), 32'(iter_of(27'h3FFFFFF, 27'h4000000)));
        wr_ready = 1'b1;
        tick();
        wait_launch("B_second_launch");
        tick();
        start = 1'b1; x_start = 27'h1234567; max_iter = 13'd5;
        tick();
        start = 1'b0;
        wait_frame("B_frame_done");
        chk("B_writes", 32'(n_last), 32'(N));
        chk("B_cr1_wrap", 32'(cap_cr[1]), 32'h4000000);
        chk("B_ci4_wrap", 32'(cap_ci[4]), 32'h0000000);
        chk("B_cr4_row", 32'(cap_cr[4]), 32'h3FFFFFF);

        // Frame C: stale done on launch and first wait cycle must be ignored
        wr_ready = 1'b0;
        skip_iter = 1'b1;
        start_frame(27'h7000000, 27'h0800000, 27'h0400000, 27'h7C00000, 13'd100);
        wait_launch("C_launch");
        ovr_en = 1'b1; ovr_done = 1'b1; ovr_iter = 13'd7;
        tick();
        tick();
        ovr_done = 1'b0;
        tick();
        ovr_done = 1'b1; ovr_iter = 13'd42;
        wait_valid("C_valid");
        chk("C_wr_iter", 32'(wr_iter), 32'd42);
        chk("C_wr_addr", 32'(wr_addr), 32'd0);
        ovr_en = 1'b0;
        wr_ready = 1'b1;
        tick();
        skip_iter = 1'b0;
        wait_frame("C_frame_done");
        chk("C_writes", 32'(n_last), 32'(N));

        // Frame D: reset mid-frame, then restart from address 0
        start_frame(27'h7800000, 27'h0800000, 27'h0400000, 27'h7C00000, 13'd100);
        n = 0;
        while (wr_addr != 19'd3 && n < 100) begin
            tick();
            n++;
        end
        if (wr_addr != 19'd3) fail_timeout("D_reach_addr3");
        fd_before = fd_cnt;
        reset = 1'b1;
        tick(); tick();
        chk("D_rst_valid", 32'(wr_valid), 32'd0);
        chk("D_rst_busy", 32'(busy), 32'd0);
        chk("D_rst_addr", 32'(wr_addr), 32'd0);
        chk("D_rst_slv_reset", 32'(slv_reset), 32'd1);
        chk("D_rst_cr", 32'(slv_cr), 32'd0);
        reset = 1'b0;
        tick();
        chk("D_no_fd", 32'(fd_cnt), 32'(fd_before));
        start_frame(27'h0200000, 27'h0800000, 27'h0400000, 27'h7C00000, 13'd100);
        wait_frame("D_frame_done");
        chk("D_first_addr", 32'(cap_addr[0]), 32'd0);
        chk("D_first_cr", 32'(cap_cr[0]), 32'h0200000);
        chk("D_writes", 32'(n_last), 32'(N));
        chk("D_fd_count", 32'(fd_cnt), 32'(fd_before + 1));

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
